// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: byte-serial loads and stores over a shared 8-bit RAM
// port, load sign/zero extension, and write-back pass-through for non-memory ops.
package mem_lsu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;
    localparam int STALL_W    = 6;

    localparam logic [ALUOP_W-1:0] EX_NOP = 8'h00;
    localparam logic [ALUOP_W-1:0] EX_ADD = 8'h01;
    localparam logic [ALUOP_W-1:0] EX_LB  = 8'h20;
    localparam logic [ALUOP_W-1:0] EX_LH  = 8'h21;
    localparam logic [ALUOP_W-1:0] EX_LW  = 8'h22;
    localparam logic [ALUOP_W-1:0] EX_LBU = 8'h24;
    localparam logic [ALUOP_W-1:0] EX_LHU = 8'h25;
    localparam logic [ALUOP_W-1:0] EX_SB  = 8'h28;
    localparam logic [ALUOP_W-1:0] EX_SH  = 8'h29;
    localparam logic [ALUOP_W-1:0] EX_SW  = 8'h2a;

    typedef struct packed {
        logic       load;
        logic       store;
        logic       sext;
        logic [2:0] nbytes;
    } op_t;
endpackage

module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [REG_ADDR_W-1:0] mem_w_addr,
    input  logic                  mem_w_req,
    input  logic [DATA_W-1:0]     mem_w_data,
    input  logic [ADDR_W-1:0]     mem_mem_addr,
    input  logic [ALUOP_W-1:0]    mem_aluop,
    input  logic [STALL_W-1:0]    stall_state,
    input  logic                  ram_grant,
    input  logic [7:0]            ram_din,
    output logic                  ram_req,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [7:0]            ram_dout,
    output logic                  ram_wr,
    output logic [REG_ADDR_W-1:0] wb_w_addr,
    output logic                  wb_w_req,
    output logic [DATA_W-1:0]     wb_w_data,
    output logic                  stall_req
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [2:0]        idx;
    logic [DATA_W-1:0] ld_buf;
    logic [DATA_W-1:0] ld_ext;
    op_t               op;
    logic              is_mem;
    logic              unused_ok;

    assign unused_ok = ^{stall_state[STALL_W-1:5], stall_state[3:0]};

    always_comb begin
        op = '0;
        case (mem_aluop)
            EX_LB:   op = '{load: 1'b1, store: 1'b0, sext: 1'b1, nbytes: 3'd1};
            EX_LBU:  op = '{load: 1'b1, store: 1'b0, sext: 1'b0, nbytes: 3'd1};
            EX_LH:   op = '{load: 1'b1, store: 1'b0, sext: 1'b1, nbytes: 3'd2};
            EX_LHU:  op = '{load: 1'b1, store: 1'b0, sext: 1'b0, nbytes: 3'd2};
            EX_LW:   op = '{load: 1'b1, store: 1'b0, sext: 1'b0, nbytes: 3'd4};
            EX_SB:   op = '{load: 1'b0, store: 1'b1, sext: 1'b0, nbytes: 3'd1};
            EX_SH:   op = '{load: 1'b0, store: 1'b1, sext: 1'b0, nbytes: 3'd2};
            EX_SW:   op = '{load: 1'b0, store: 1'b1, sext: 1'b0, nbytes: 3'd4};
            default: op = '0;
        endcase
    end

    assign is_mem = op.load | op.store;

    always_comb begin
        ld_ext = ld_buf;
        case (op.nbytes)
            3'd1:    ld_ext = {{(DATA_W-8){op.sext & ld_buf[7]}}, ld_buf[7:0]};
            3'd2:    ld_ext = {{(DATA_W-16){op.sext & ld_buf[15]}}, ld_buf[15:0]};
            default: ld_ext = ld_buf;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx       = '0;
        ram_req   = 1'b0;
        ram_wr    = 1'b0;
        ram_addr  = '0;
        ram_dout  = '0;
        stall_req = 1'b0;
        wb_w_addr = '0;
        wb_w_req  = 1'b0;
        wb_w_data = '0;
        case (state)
            IDLE: begin
                if (!is_mem) begin
                    wb_w_addr = mem_w_addr;
                    wb_w_req  = mem_w_req;
                    wb_w_data = mem_w_data;
                end else begin
                    stall_req = 1'b1;
                    ram_req   = 1'b1;
                    // Byte 0 goes out on the granting edge itself.
                    if (ram_grant) begin
                        ram_addr  = mem_mem_addr;
                        ram_wr    = op.store;
                        ram_dout  = mem_w_data[7:0];
                        cnt_nxt   = 3'd1;
                        state_nxt = (op.store && op.nbytes == 3'd1) ? DONE : ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall_req = 1'b1;
                ram_req   = 1'b1;
                if (op.store) begin
                    idx      = cnt;
                    ram_wr   = 1'b1;
                    ram_addr = mem_mem_addr + ADDR_W'(idx);
                    ram_dout = 8'(mem_w_data >> {idx, 3'b000});
                    if (cnt == op.nbytes - 3'd1) state_nxt = DONE;
                    else                         cnt_nxt   = cnt + 3'd1;
                end else begin
                    // While frozen, or once every byte is out, re-read the byte awaiting
                    // capture so ram_din still holds it on the next enabled edge.
                    idx      = (cnt < op.nbytes && rdy) ? cnt : cnt - 3'd1;
                    ram_addr = mem_mem_addr + ADDR_W'(idx);
                    if (cnt == op.nbytes) state_nxt = DONE;
                    else                  cnt_nxt   = cnt + 3'd1;
                end
            end
            DONE: begin
                if (op.load) begin
                    wb_w_addr = mem_w_addr;
                    wb_w_req  = mem_w_req;
                    wb_w_data = ld_ext;
                end
                if (!stall_state[4]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rdy) ram_wr = 1'b0;
        if (!rst) begin
            ram_req   = 1'b0;
            ram_wr    = 1'b0;
            ram_addr  = '0;
            ram_dout  = '0;
            stall_req = 1'b0;
            wb_w_addr = '0;
            wb_w_req  = 1'b0;
            wb_w_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            ld_buf <= '0;
        end else if (rdy) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // cnt-1 is the byte whose data is on ram_din this cycle.
            if (state == ACCESS && op.load) begin
                for (int b = 0; b < 4; b++)
                    if (cnt == 3'(b + 1)) ld_buf[8*b +: 8] <= ram_din;
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: byte-wide sync RAM model, grant-on-request arbiter.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [4:0]  mem_w_addr;
    logic        mem_w_req;
    logic [31:0] mem_w_data, mem_mem_addr;
    logic [7:0]  mem_aluop;
    logic [5:0]  stall_state;
    logic        ram_grant, grant_en;
    logic [7:0]  ram_din;
    logic        ram_req, ram_wr, wb_w_req, stall_req;
    logic [31:0] ram_addr, wb_w_data;
    logic [7:0]  ram_dout;
    logic [4:0]  wb_w_addr;

    int n_chk = 0, n_fail = 0;
    int n_acc = 0;
    logic [7:0]  mem [logic [31:0]];
    logic [31:0] wlog_a[$];
    logic [7:0]  wlog_d[$];
    logic [31:0] aq[$];

    always #5 clk = ~clk;

    assign ram_grant = grant_en & ram_req;

    mem_lsu dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_w_addr(mem_w_addr), .mem_w_req(mem_w_req), .mem_w_data(mem_w_data),
        .mem_mem_addr(mem_mem_addr), .mem_aluop(mem_aluop), .stall_state(stall_state),
        .ram_grant(ram_grant), .ram_din(ram_din),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr),
        .wb_w_addr(wb_w_addr), .wb_w_req(wb_w_req), .wb_w_data(wb_w_data),
        .stall_req(stall_req)
    );

    // Synchronous RAM: read data appears the cycle after its address is sampled.
    always @(posedge clk) begin
        if (ram_req && ram_grant) begin
            n_acc = n_acc + 1;
            if (ram_wr) begin
                mem[ram_addr] = ram_dout;
                wlog_a.push_back(ram_addr);
                wlog_d.push_back(ram_dout);
            end
        end
        ram_din <= mem.exists(ram_addr) ? mem[ram_addr] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_op(input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] d, input logic [4:0] wa);
        mem_aluop    = op;
        mem_mem_addr = a;
        mem_w_data   = d;
        mem_w_addr   = wa;
        mem_w_req    = 1'b1;
        #1;
    endtask

    // Counts stalled cycles and logs granted addresses until stall_req drops.
    task automatic wait_done(output int stalls);
        stalls = 0;
        aq.delete();
        while (stall_req === 1'b1 && stalls < 20) begin
            if (ram_req && ram_grant) aq.push_back(ram_addr);
            stalls++;
            tick();
        end
        chk("stall_drop", {31'd0, stall_req}, 32'd0);
    endtask

    task automatic end_op();
        tick();
        mem_aluop = EX_NOP;
        mem_w_req = 1'b0;
        #1;
    endtask

    task automatic run_load(input string tag, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] exp, input int exp_stalls);
        int s;
        drive_op(op, a, 32'h0, 5'd3);
        wait_done(s);
        chk({tag, "_stalls"}, s, exp_stalls);
        chk({tag, "_data"}, wb_w_data, exp);
        chk({tag, "_wreq"}, {31'd0, wb_w_req}, 32'd1);
        end_op();
    endtask

    task automatic run_store(input string tag, input logic [7:0] op, input logic [31:0] a,
                             input logic [31:0] d, input int exp_stalls);
        int s;
        drive_op(op, a, d, 5'd3);
        wait_done(s);
        chk({tag, "_stalls"}, s, exp_stalls);
        chk({tag, "_wreq"}, {31'd0, wb_w_req}, 32'd0);
        end_op();
    endtask

    initial begin
        int s, n0, w0;
        rst = 1'b0; rdy = 1'b1; grant_en = 1'b1; stall_state = '0;
        mem_aluop = EX_NOP; mem_w_addr = '0; mem_w_req = 1'b0;
        mem_w_data = '0; mem_mem_addr = '0;
        tick(); tick();
        chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_wb_data", wb_w_data, 32'd0);
        rst = 1'b1;
        tick();

        // Pass-through is combinational, visible in the same cycle.
        mem_aluop = EX_ADD; mem_w_addr = 5'd5; mem_w_data = 32'h1234; mem_w_req = 1'b1;
        #1;
        chk("pt_waddr", {27'd0, wb_w_addr}, 32'd5);
        chk("pt_wdata", wb_w_data, 32'h1234);
        chk("pt_wreq", {31'd0, wb_w_req}, 32'd1);
        chk("pt_stall", {31'd0, stall_req}, 32'd0);
        chk("pt_ram_req", {31'd0, ram_req}, 32'd0);
        end_op();

        // SW lays down 78 56 34 12 at 0x100..0x103.
        w0 = wlog_a.size();
        run_store("sw", EX_SW, 32'h100, 32'h12345678, 4);
        chk("sw_nwr", wlog_a.size() - w0, 4);
        chk("sw_b0", {24'd0, wlog_d[w0]}, 32'h78);
        chk("sw_a3", wlog_a[w0+3], 32'h103);
        chk("sw_b3", {24'd0, wlog_d[w0+3]}, 32'h12);

        // LW: addresses on consecutive cycles, stall for exactly five cycles.
        drive_op(EX_LW, 32'h100, 32'h0, 5'd7);
        wait_done(s);
        chk("lw_stalls", s, 5);
        chk("lw_a0", aq[0], 32'h100);
        chk("lw_a1", aq[1], 32'h101);
        chk("lw_a2", aq[2], 32'h102);
        chk("lw_a3", aq[3], 32'h103);
        chk("lw_data", wb_w_data, 32'h12345678);
        chk("lw_waddr", {27'd0, wb_w_addr}, 32'd7);
        end_op();

        run_store("sb", EX_SB, 32'h200, 32'h00000080, 1);
        run_load("lb", EX_LB, 32'h200, 32'hFFFFFF80, 2);
        run_load("lbu", EX_LBU, 32'h200, 32'h00000080, 2);
        run_store("sh", EX_SH, 32'h300, 32'h00009001, 2);
        run_load("lh", EX_LH, 32'h300, 32'hFFFF9001, 3);
        run_load("lhu", EX_LHU, 32'h300, 32'h00009001, 3);

        // Halfword store wrapping past the top of the address space.
        w0 = wlog_a.size();
        run_store("shw", EX_SH, 32'hFFFFFFFF, 32'hAABBCCDD, 2);
        chk("shw_nwr", wlog_a.size() - w0, 2);
        chk("shw_a0", wlog_a[w0], 32'hFFFFFFFF);
        chk("shw_d0", {24'd0, wlog_d[w0]}, 32'hDD);
        chk("shw_a1", wlog_a[w0+1], 32'h0);
        chk("shw_d1", {24'd0, wlog_d[w0+1]}, 32'hCC);

        // No grant: wait in IDLE with the request up. Then hold DONE via stall_state[4].
        grant_en = 1'b0;
        n0 = n_acc;
        drive_op(EX_LW, 32'h100, 32'h0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            chk("ng_req", {31'd0, ram_req}, 32'd1);
            chk("ng_addr", ram_addr, 32'd0);
            chk("ng_stall", {31'd0, stall_req}, 32'd1);
            tick();
        end
        chk("ng_acc", n_acc, n0);
        grant_en = 1'b1;
        stall_state = 6'b010000;
        wait_done(s);
        chk("hold_stalls", s, 5);
        n0 = n_acc;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold_data", wb_w_data, 32'h12345678);
            chk("hold_wreq", {31'd0, wb_w_req}, 32'd1);
            chk("hold_stall", {31'd0, stall_req}, 32'd0);
            chk("hold_req", {31'd0, ram_req}, 32'd0);
        end
        stall_state = '0;
        end_op();
        tick();
        chk("hold_acc", n_acc, n0);

        // Reset in the middle of an LW abandons it.
        drive_op(EX_LW, 32'h100, 32'h0, 5'd4);
        tick(); tick();
        rst = 1'b0;
        #1;
        n0 = n_acc;
        for (int i = 0; i < 2; i++) begin
            chk("mr_req", {31'd0, ram_req}, 32'd0);
            chk("mr_wr", {31'd0, ram_wr}, 32'd0);
            chk("mr_stall", {31'd0, stall_req}, 32'd0);
            chk("mr_wreq", {31'd0, wb_w_req}, 32'd0);
            tick();
        end
        chk("mr_acc", n_acc, n0);
        mem_aluop = EX_NOP; mem_w_req = 1'b0;
        rst = 1'b1;
        tick();
        chk("post_rst_stall", {31'd0, stall_req}, 32'd0);
        chk("post_rst_req", {31'd0, ram_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit: the consumer of the EX/MEM pipeline register outputs (w_addr, w_req, w_data, mem_addr, aluop).
- Loads and stores are executed over the shared byte-wide synchronous RAM port. Load results are assembled, sign- or zero-extended, and presented as the write-back triple to MEM/WB.
- Non-memory ops pass straight through.
- stall_req is raised while an access is in flight, so the stall controller holds EX/MEM stable.

Parameters:
- ADDR_W, 32, RAM byte-address width (`MemBus`).
- DATA_W, 32, register width (`RegBus`).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- rdy  in  1  global enable; low freezes all state.
- mem_w_addr  in  `RegAddrBus`  destination register from EX/MEM.
- mem_w_req  in  1  register-write request from EX/MEM.
- mem_w_data  in  `RegBus`  ALU result; store data for store ops.
- mem_mem_addr  in  `MemBus`  effective byte address.
- mem_aluop  in  `AluOpBus`  operation code.
- stall_state  in  `StallBus`  bit[4] high = MEM/WB holding.
- ram_grant  in  1  arbiter grants RAM port to this unit.
- ram_din  in  8  RAM read byte, valid the cycle after its address.
- ram_req  out  1  request the RAM port.
- ram_addr  out  `MemBus`  byte address.
- ram_dout  out  8  write byte.
- ram_wr  out  1  1 = write, 0 = read.
- wb_w_addr  out  `RegAddrBus`  to MEM/WB.
- wb_w_req  out  1  to MEM/WB.
- wb_w_data  out  `RegBus`  to MEM/WB.
- stall_req  out  1  MEM-stage stall request.

Behaviour:
- Memory ops: EX_LB/LBU (1 byte), EX_LH/LHU (2 bytes), EX_LW (4 bytes), EX_SB/SH/SW (1/2/4 bytes). Every other aluop is non-memory.
- Byte i (i = 0..n-1) uses address mem_mem_addr+i, modulo 2^32. Ordering is little-endian; misaligned addresses are used as-is.
- Store byte i = mem_w_data[8i+7:8i].
- Reset (rst==0 at posedge, independent of rdy):
  - FSM -> IDLE; byte counters -> 0; load buffer -> 0.
  - ram_req=0, ram_wr=0, ram_addr=0, ram_dout=0.
  - stall_req=0, wb_w_req=0, wb_w_addr=0, wb_w_data=0.
  - Reset mid-access abandons the access with no further RAM writes.
- rdy==0: no state change, ram_wr forced 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Non-memory op: wb_* = mem_w_* combinationally; stall_req=0.
  - Memory op: stall_req=1, ram_req=1, wb_w_req=0.
  - ram_grant==1 at posedge -> ACCESS, with byte 0 issued on the same edge.
  - No grant: remain in IDLE.
- Grant contract: once granted, the arbiter holds the grant until ram_req drops. ram_grant is ignored outside IDLE.
- ACCESS, loads:
  - ram_wr=0. One byte address is issued per cycle.
  - Each cycle captures the byte issued in the previous cycle.
  - After byte n-1 is captured -> DONE.
  - LW: the edge entering ACCESS is cycle 0; DONE is reached at cycle 4.
- ACCESS, stores:
  - ram_wr=1 with ram_addr/ram_dout for byte i.
  - After byte n-1 is written -> DONE.
  - SW: four write cycles.
- DONE:
  - ram_req=0, ram_wr=0, stall_req=0.
  - Load: wb_w_addr = mem_w_addr, wb_w_req = mem_w_req, wb_w_data = extended result. LB/LH sign-extend; LBU/LHU zero-extend.
  - Store: wb_w_req=0.
  - -> IDLE when stall_state[4]==0; otherwise hold DONE with outputs stable. This prevents re-executing the same op while the pipeline is held.
- A memory op is executed exactly once per EX/MEM entry. Inputs are required to be stable while stall_req==1.

Test Plan:
- Reset: rst=0 for 2 cycles during an LW in ACCESS -> ram_req, ram_wr, stall_req, wb_w_req all 0; no further RAM accesses.
- Pass-through: aluop=EX_ADD, w_addr=5, w_data=0x1234, w_req=1 -> wb_* equal inputs in the same cycle; stall_req=0.
- LW: addr 0x100, RAM bytes 0x100..0x103 = 78 56 34 12, grant=1.
  - ram_addr = 0x100..0x103 on consecutive cycles.
  - DONE: wb_w_data=0x12345678; stall_req high for exactly 5 cycles.
- LB vs LBU: byte 0x80 at 0x200 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SH: addr 0xFFFFFFFF, data 0xAABBCCDD -> writes DD @0xFFFFFFFF, then CC @0x00000000 (wrap); wb_w_req=0.
- Grant/hold: grant=0 for 3 cycles -> IDLE with ram_req=1, no address issued. Then stall_state[4]=1 in DONE for 2 cycles -> outputs held, no second access.
